// File: rtl/alu_pkg.sv
// Shared ALU definitions: state encoding and default datapath widths used by the
// sequencer, the ALU and the display blocks.
package alu_pkg;

   localparam int unsigned STATE_W   = 3;
   localparam int unsigned ALU_WIDTH = 8;
   localparam int unsigned ALU_OPW   = 4;

   typedef enum logic [STATE_W-1:0] {
      StEnterA  = 3'd0,
      StEnterB  = 3'd1,
      StEnterOp = 3'd2,
      StLaunch  = 3'd3,
      StWait    = 3'd4,
      StShow    = 3'd5
   } state_e;

endpackage

// File: rtl/wait_timer.sv
// Saturating watchdog counter for the ALU response wait.
// expired fires on the cycle whose increment would land the count on TIMEOUT-1.
module wait_timer #(
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W  = $clog2(TIMEOUT) + 1;
   localparam int unsigned EXP_AT = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && (count_q != LAST)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign expired = (count_q >= CNT_W'(EXP_AT));

endmodule

// File: rtl/alu_input_sequencer.sv
// Button-driven entry of operand A, operand B and opcode, followed by an ALU
// start/done handshake guarded by a watchdog; result is held for display.
module alu_input_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH   = ALU_WIDTH,
   parameter int unsigned OPW     = ALU_OPW,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               next_pulse,
   input  logic               back_pulse,
   input  logic [WIDTH-1:0]   switches,
   input  logic               alu_done,
   input  logic [WIDTH-1:0]   alu_result,
   output logic [WIDTH-1:0]   operand_a,
   output logic [WIDTH-1:0]   operand_b,
   output logic [OPW-1:0]     opcode,
   output logic               start,
   output logic [WIDTH-1:0]   result,
   output logic               result_valid,
   output logic               timeout_err,
   output logic [STATE_W-1:0] state
);

   state_e           state_q;
   logic [WIDTH-1:0] operand_a_q;
   logic [WIDTH-1:0] operand_b_q;
   logic [OPW-1:0]   opcode_q;
   logic [WIDTH-1:0] result_q;
   logic             start_q;
   logic             result_valid_q;
   logic             timeout_err_q;

   logic next_ev;
   logic back_ev;
   logic timer_clear;
   logic timer_enable;
   logic timer_expired;

   // Simultaneous presses cancel each other out.
   assign next_ev = next_pulse & ~back_pulse;
   assign back_ev = back_pulse & ~next_pulse;

   assign timer_clear  = (state_q == StLaunch);
   assign timer_enable = (state_q == StWait) & ~alu_done;

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= StEnterA;
         operand_a_q    <= '0;
         operand_b_q    <= '0;
         opcode_q       <= '0;
         result_q       <= '0;
         start_q        <= 1'b0;
         result_valid_q <= 1'b0;
         timeout_err_q  <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            StEnterA: begin
               if (next_ev) begin
                  operand_a_q <= switches;
                  state_q     <= StEnterB;
               end
            end
            StEnterB: begin
               if (next_ev) begin
                  operand_b_q <= switches;
                  state_q     <= StEnterOp;
               end else if (back_ev) begin
                  state_q <= StEnterA;
               end
            end
            StEnterOp: begin
               if (next_ev) begin
                  opcode_q <= switches[OPW-1:0];
                  start_q  <= 1'b1;
                  state_q  <= StLaunch;
               end else if (back_ev) begin
                  state_q <= StEnterB;
               end
            end
            StLaunch: begin
               state_q <= StWait;
            end
            StWait: begin
               // A done arriving on the expiry cycle still counts as completion.
               if (alu_done) begin
                  result_q       <= alu_result;
                  result_valid_q <= 1'b1;
                  state_q        <= StShow;
               end else if (timer_expired) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= StShow;
               end
            end
            StShow: begin
               if (next_ev || back_ev) begin
                  result_valid_q <= 1'b0;
                  timeout_err_q  <= 1'b0;
                  state_q        <= StEnterA;
               end
            end
            default: begin
               state_q <= StEnterA;
            end
         endcase
      end
   end

   assign operand_a    = operand_a_q;
   assign operand_b    = operand_b_q;
   assign opcode       = opcode_q;
   assign start        = start_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign timeout_err  = timeout_err_q;
   assign state        = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer: behavioural model checked every cycle
// plus hand-computed spot checks along the test plan.
module tb_alu_input_sequencer;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned OPW     = 4;
   localparam int unsigned TIMEOUT = 8;
   // WAIT cycles before the watchdog gives up (start cycle + this = TIMEOUT)
   localparam int WAIT_LIMIT = (TIMEOUT > 1) ? TIMEOUT - 1 : 1;

   logic             clock = 1'b0;
   logic             reset;
   logic             next_pulse;
   logic             back_pulse;
   logic [WIDTH-1:0] switches;
   logic             alu_done;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [OPW-1:0]   opcode;
   logic             start;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   logic             timeout_err;
   logic [2:0]       state;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   alu_input_sequencer #(
      .WIDTH   (WIDTH),
      .OPW     (OPW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .next_pulse   (next_pulse),
      .back_pulse   (back_pulse),
      .switches     (switches),
      .alu_done     (alu_done),
      .alu_result   (alu_result),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .opcode       (opcode),
      .start        (start),
      .result       (result),
      .result_valid (result_valid),
      .timeout_err  (timeout_err),
      .state        (state)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase number, latched values, and WAIT cycles elapsed.
   int         m_state;
   logic [7:0] m_a, m_b, m_res;
   logic [3:0] m_op;
   bit         m_rv, m_te;
   int         m_w;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_state <= 0; m_a <= 8'h00; m_b <= 8'h00; m_op <= 4'h0; m_res <= 8'h00;
         m_rv <= 1'b0; m_te <= 1'b0; m_w <= 0;
      end else begin
         case (m_state)
            0: if (next_pulse && !back_pulse) begin m_a <= switches; m_state <= 1; end
            1: if (next_pulse && !back_pulse) begin m_b <= switches; m_state <= 2; end
               else if (back_pulse && !next_pulse) m_state <= 0;
            2: if (next_pulse && !back_pulse) begin m_op <= switches[3:0]; m_state <= 3; end
               else if (back_pulse && !next_pulse) m_state <= 1;
            3: begin m_state <= 4; m_w <= 1; end
            4: if (alu_done) begin m_res <= alu_result; m_rv <= 1'b1; m_state <= 5; end
               else if (m_w >= WAIT_LIMIT) begin m_te <= 1'b1; m_state <= 5; end
               else m_w <= m_w + 1;
            5: if (next_pulse ^ back_pulse) begin m_rv <= 1'b0; m_te <= 1'b0; m_state <= 0; end
            default: m_state <= 0;
         endcase
      end
   end

   always @(negedge clock) begin
      if (checking) begin
         check("model state", 32'(state), 32'(m_state));
         check("model operand_a", 32'(operand_a), 32'(m_a));
         check("model operand_b", 32'(operand_b), 32'(m_b));
         check("model opcode", 32'(opcode), 32'(m_op));
         check("model start", 32'(start), 32'(m_state == 3));
         check("model result", 32'(result), 32'(m_res));
         check("model result_valid", 32'(result_valid), 32'(m_rv));
         check("model timeout_err", 32'(timeout_err), 32'(m_te));
      end
   end

   // Called at a falling edge; drives one pulse cycle and returns at the next one.
   task automatic pulse(input logic nx, input logic bk, input logic [7:0] sw);
      switches   = sw;
      next_pulse = nx;
      back_pulse = bk;
      @(negedge clock);
      next_pulse = 1'b0;
      back_pulse = 1'b0;
   endtask

   initial begin
      reset = 1'b1; next_pulse = 1'b0; back_pulse = 1'b0;
      switches = 8'h00; alu_done = 1'b0; alu_result = 8'h00;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      checking = 1'b1;
      check("reset state", 32'(state), 32'd0);
      check("reset operand_a", 32'(operand_a), 32'h0);
      check("reset result", 32'(result), 32'h0);
      check("reset flags", 32'({start, result_valid, timeout_err}), 32'h0);

      // Nominal flow
      pulse(1'b1, 1'b0, 8'h12);
      check("nom A state", 32'(state), 32'd1);
      check("nom A value", 32'(operand_a), 32'h12);
      pulse(1'b1, 1'b0, 8'h34);
      check("nom B value", 32'(operand_b), 32'h34);
      pulse(1'b1, 1'b0, 8'h03);
      check("nom start high", 32'(start), 32'd1);
      check("nom opcode", 32'(opcode), 32'h3);
      @(negedge clock);
      check("nom start one cycle", 32'(start), 32'd0);
      check("nom wait state", 32'(state), 32'd4);
      @(negedge clock);
      @(negedge clock);
      alu_done = 1'b1; alu_result = 8'h46;
      @(negedge clock);
      alu_done = 1'b0; alu_result = 8'h00;
      check("nom result", 32'(result), 32'h46);
      check("nom result_valid", 32'(result_valid), 32'd1);
      check("nom show state", 32'(state), 32'd5);
      pulse(1'b0, 1'b1, 8'h00);
      check("show exit state", 32'(state), 32'd0);
      check("show exit valid", 32'(result_valid), 32'd0);

      // Back navigation
      pulse(1'b0, 1'b1, 8'h00);
      check("back in A", 32'(state), 32'd0);
      pulse(1'b1, 1'b0, 8'hAA);
      check("back A1", 32'(state), 32'd1);
      pulse(1'b0, 1'b1, 8'h00);
      check("back to A", 32'(state), 32'd0);
      check("back keeps A", 32'(operand_a), 32'hAA);
      pulse(1'b1, 1'b0, 8'h55);
      check("back reenter", 32'(state), 32'd1);
      check("back A overwrite", 32'(operand_a), 32'h55);

      // Simultaneous pulses in ENTER_B
      pulse(1'b1, 1'b1, 8'h77);
      check("both state", 32'(state), 32'd1);
      check("both operand_b", 32'(operand_b), 32'h34);

      // Timeout with no alu_done
      pulse(1'b1, 1'b0, 8'hBB);
      pulse(1'b1, 1'b0, 8'h05);
      repeat (TIMEOUT - 1) @(negedge clock);
      check("to still waiting", 32'(state), 32'd4);
      @(negedge clock);
      check("to show", 32'(state), 32'd5);
      check("to err", 32'(timeout_err), 32'd1);
      check("to valid", 32'(result_valid), 32'd0);
      check("to result held", 32'(result), 32'h46);
      pulse(1'b1, 1'b0, 8'h00);
      check("to clear err", 32'(timeout_err), 32'd0);

      // alu_done on the expiry cycle
      pulse(1'b1, 1'b0, 8'h01);
      pulse(1'b1, 1'b0, 8'h02);
      pulse(1'b1, 1'b0, 8'h0A);
      repeat (TIMEOUT - 1) @(negedge clock);
      alu_done = 1'b1; alu_result = 8'h9C;
      @(negedge clock);
      alu_done = 1'b0;
      check("race show", 32'(state), 32'd5);
      check("race valid", 32'(result_valid), 32'd1);
      check("race err", 32'(timeout_err), 32'd0);
      check("race result", 32'(result), 32'h9C);
      pulse(1'b0, 1'b1, 8'h00);

      // Asynchronous reset in WAIT
      pulse(1'b1, 1'b0, 8'h21);
      pulse(1'b1, 1'b0, 8'h43);
      pulse(1'b1, 1'b0, 8'h07);
      @(negedge clock);
      check("arst in wait", 32'(state), 32'd4);
      #2 reset = 1'b1;
      #1;
      check("arst state", 32'(state), 32'd0);
      check("arst operands", 32'({operand_a, operand_b, opcode}), 32'h0);
      check("arst result", 32'(result), 32'h0);
      check("arst flags", 32'({start, result_valid, timeout_err}), 32'h0);
      @(negedge clock);
      reset = 1'b0;
      alu_done = 1'b1; alu_result = 8'hEE;
      @(negedge clock);
      alu_done = 1'b0;
      check("late done state", 32'(state), 32'd0);
      check("late done result", 32'(result), 32'h0);
      repeat (3) @(negedge clock);
      check("no restart", 32'(start), 32'd0);

      // Auto-repeat: pulse every 5 cycles
      for (int i = 0; i < 4; i++) begin
         pulse(1'b1, 1'b0, 8'h0F);
         if (i == 2) begin
            check("rep launch", 32'(state), 32'd3);
            check("rep operands", 32'({operand_a, operand_b, opcode}), 32'h0F0FF);
         end
         if (i == 3) check("rep wait ignores", 32'(state), 32'd4);
         repeat (4) @(negedge clock);
      end
      repeat (4) @(negedge clock);
      check("rep timeout", 32'(timeout_err), 32'd1);

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
- Sits directly downstream of the button debouncers; consumes their one-cycle press pulses.
- Walks the user through entering operand A, operand B and opcode from board switches, then launches the ALU with a start/done handshake.
- Captures the ALU result for display, with a watchdog timeout on the ALU response.

Parameters:
- WIDTH, 8, operand/result width in bits
- OPW, 4, opcode width in bits (taken from switches[OPW-1:0]); OPW <= WIDTH
- TIMEOUT, 1000, max cycles to wait for alu_done after start; must be >= 1

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; forces reset state immediately
- next_pulse  input  1  debounced "advance" press, one-cycle high per event
- back_pulse  input  1  debounced "back" press, one-cycle high per event
- switches  input  WIDTH  raw switch value sampled on next_pulse
- alu_done  input  1  ALU completion, one-cycle or level; sampled only in WAIT
- alu_result  input  WIDTH  ALU output, valid when alu_done=1
- operand_a  output  WIDTH  latched operand A
- operand_b  output  WIDTH  latched operand B
- opcode  output  OPW  latched opcode
- start  output  1  one-cycle ALU launch strobe
- result  output  WIDTH  captured ALU result
- result_valid  output  1  high in SHOW after a normal completion
- timeout_err  output  1  high in SHOW after a watchdog expiry
- state  output  3  current state encoding, drives status LEDs

Behaviour:
- Reset:
  - State goes to ENTER_A.
  - operand_a, operand_b, opcode and result are 0.
  - start, result_valid and timeout_err are 0.
  - Watchdog counter is 0.
- State encoding: ENTER_A=0, ENTER_B=1, ENTER_OP=2, LAUNCH=3, WAIT=4, SHOW=5. Codes 6 and 7 are illegal and go to ENTER_A on the next clock.
- Event qualification:
  - next_ev = next_pulse & ~back_pulse
  - back_ev = back_pulse & ~next_pulse
  - Both high in the same cycle: no event, state unchanged.
- Transitions (one clock per step):
  - ENTER_A: next_ev -> operand_a <= switches, go ENTER_B. back_ev ignored.
  - ENTER_B: next_ev -> operand_b <= switches, go ENTER_OP. back_ev -> ENTER_A; operand_a is kept.
  - ENTER_OP: next_ev -> opcode <= switches[OPW-1:0], go LAUNCH. back_ev -> ENTER_B.
  - LAUNCH: start=1 for exactly this one cycle; watchdog counter cleared; unconditionally go WAIT. Pulses ignored.
  - WAIT:
    - alu_done=1 -> result <= alu_result, result_valid <= 1, go SHOW.
    - Else counter increments. When counter reaches TIMEOUT-1 without alu_done -> timeout_err <= 1, result unchanged, go SHOW.
    - alu_done in the same cycle as expiry: done wins (normal completion).
    - Pulses ignored.
  - SHOW: next_ev or back_ev -> clear result_valid and timeout_err, go ENTER_A. Operands and opcode are kept so re-entry overwrites them. result holds until the next capture.
- Timing and latency:
  - start rises exactly one cycle after the next_ev that latches opcode.
  - result_valid rises the cycle after alu_done is sampled in WAIT.
  - alu_done in any state other than WAIT is ignored.
- Auto-repeat: a held button produces repeated debouncer pulses; each pulse is a separate event. No extra filtering is done here.
- Reset mid-operation (including in WAIT with start already issued): immediate return to the reset state. The in-flight ALU result is discarded.
- Watchdog counter width: clog2(TIMEOUT)+1 bits, saturating; never wraps.

Decomposition:
- Shared package alu_pkg:
  - state encoding constants (ENTER_A..SHOW)
  - STATE_W=3
  - default WIDTH/OPW values, shared with the ALU and display blocks
- One sub-module: wait_timer.
  - Behaviour: clear, enable and expired; parameter TIMEOUT.
  - Holds the saturating counter so the sequencer FSM stays a pure next-state/output block.

Test Plan:
- Nominal flow: reset; switches=8'h12, next; switches=8'h34, next; switches=8'h03, next; alu_done with alu_result=8'h46 three cycles after start.
  - Required: operand_a=12, operand_b=34, opcode=3.
  - Required: start high exactly one cycle, the cycle after the third next.
  - Required: result=46 and result_valid=1 one cycle after alu_done; state=5.
- Back navigation: enter A=8'hAA, next; back; switches=8'h55, next.
  - Required: state goes 1 -> 0 -> 1; operand_a=55.
  - Required: back in ENTER_A leaves state=0.
- Simultaneous pulses: next_pulse and back_pulse both high in ENTER_B -> state stays 1 and operand_b is unchanged.
- Timeout: TIMEOUT=8, no alu_done after start.
  - Required: SHOW entered 8 cycles after start with timeout_err=1, result_valid=0, result unchanged.
  - Repeat with alu_done at the expiry cycle -> result_valid=1, timeout_err=0.
- Async reset mid-WAIT: assert reset between clock edges.
  - Required: outputs drop to 0 and state=0 before the next edge.
  - Required: a later alu_done is ignored and start does not reassert.
- Auto-repeat: next_pulse asserted every 5 cycles with switches fixed at 8'h0F from ENTER_A.
  - Required: three pulses reach LAUNCH with A=B=0F, opcode=F.
  - Required: pulses during WAIT do not change state.
